// File: rtl/fft_pkg.sv
// Shared helpers for the FFT datapath: index width, bit reversal and the
// packed-frame slot offsets used by both the input buffer and the butterfly.
package fft_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < w; i++) begin
            if (v[i]) r[w-1-i] = 1'b1;
        end
        return r;
    endfunction

    // Slot k occupies two adjacent components: real first, imaginary above it.
    function automatic int unsigned real_lsb(input int unsigned k, input int unsigned dw);
        return dw * 2 * k;
    endfunction

    function automatic int unsigned imag_lsb(input int unsigned k, input int unsigned dw);
        return dw * (2 * k + 1);
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-slot complex sample bank with per-slot write, packed read-out and a
// full flag that marks a complete frame awaiting the consumer.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 16,
    localparam int IDX_W     = idx_width(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_slot,
    input  logic [DATA_WIDTH-1:0]     wr_real,
    input  logic [DATA_WIDTH-1:0]     wr_imag,
    input  logic                      set_full,
    input  logic                      clr_full,
    output logic                      full,
    output logic [DATA_WIDTH*2*N-1:0] data_out
);

    logic [DATA_WIDTH-1:0] real_q [N];
    logic [DATA_WIDTH-1:0] real_d [N];
    logic [DATA_WIDTH-1:0] imag_q [N];
    logic [DATA_WIDTH-1:0] imag_d [N];
    logic                  full_q;
    logic                  full_d;

    always_comb begin
        real_d = real_q;
        imag_d = imag_q;
        full_d = full_q;
        if (wr_en) begin
            real_d[wr_slot] = wr_real;
            imag_d[wr_slot] = wr_imag;
        end
        if (clr_full) full_d = 1'b0;
        if (set_full) full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                real_q[k] <= '0;
                imag_q[k] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            real_q <= real_d;
            imag_q <= imag_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign data_out[real_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = real_q[k];
        assign data_out[imag_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = imag_q[k];
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame collector: assembles streamed complex samples into N-sample
// frames in two banks and hands complete frames to the butterfly stage.
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int N           = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int BIT_REVERSE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_real,
    input  logic [DATA_WIDTH-1:0]     in_imag,
    input  logic                      in_sof,
    output logic [DATA_WIDTH*2*N-1:0] cplx_data_out,
    output logic                      en_out,
    input  logic                      out_ready,
    output logic                      frame_err
);

    localparam int             IW       = idx_width(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          frame_err_q, frame_err_d;

    logic                      full0, full1;
    logic [DATA_WIDTH*2*N-1:0] bank_data0, bank_data1;

    logic          accept, restart, complete, release_rd;
    logic [IW-1:0] base_idx, wr_slot;

    assign in_ready      = wr_bank_q ? !full1 : !full0;
    assign en_out        = rd_bank_q ? full1 : full0;
    assign cplx_data_out = rd_bank_q ? bank_data1 : bank_data0;
    assign frame_err     = frame_err_q;

    always_comb begin
        accept     = in_valid && in_ready;
        // A start-of-frame in the middle of a frame abandons the partial frame.
        restart    = accept && in_sof && (wr_idx_q != '0);
        complete   = accept && !restart && (wr_idx_q == LAST_IDX);
        release_rd = en_out && out_ready;
        base_idx   = restart ? '0 : wr_idx_q;
        wr_slot    = (BIT_REVERSE != 0) ? IW'(bitrev(32'(base_idx), IW)) : base_idx;

        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_err_d = restart;
        if (accept) begin
            if (restart) begin
                wr_idx_d = IW'(1);
            end else if (complete) begin
                wr_idx_d  = '0;
                wr_bank_d = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
        if (release_rd) rd_bank_d = !rd_bank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            frame_err_q <= frame_err_d;
        end
    end

    fft_frame_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept && !wr_bank_q),
        .wr_slot  (wr_slot),
        .wr_real  (in_real),
        .wr_imag  (in_imag),
        .set_full (complete && !wr_bank_q),
        .clr_full (release_rd && !rd_bank_q),
        .full     (full0),
        .data_out (bank_data0)
    );

    fft_frame_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept && wr_bank_q),
        .wr_slot  (wr_slot),
        .wr_real  (in_real),
        .wr_imag  (in_imag),
        .set_full (complete && wr_bank_q),
        .clr_full (release_rd && rd_bank_q),
        .full     (full1),
        .data_out (bank_data1)
    );

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter N, default 2, meaning complex samples per frame; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning bits per real or imaginary component.
REQ-003 SHALL have parameter BIT_REVERSE, default 0, meaning 1 stores each sample at the bit-reversed position of its arrival index.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have in_valid  input  1  sample present.
REQ-007 SHALL have in_ready  output  1  sample will be accepted this cycle.
REQ-008 SHALL have in_real  input  DATA_WIDTH  real component.
REQ-009 SHALL have in_imag  input  DATA_WIDTH  imaginary component.
REQ-010 SHALL have in_sof  input  1  sample is the first of a frame.
REQ-011 SHALL have cplx_data_out  output  DATA_WIDTH*2*N  packed frame: slot k real at [DATA_WIDTH*(2k+1)-1 -: DATA_WIDTH], imag at [DATA_WIDTH*(2k+2)-1 -: DATA_WIDTH].
REQ-012 SHALL have en_out  output  1  frame valid; drives downstream butterfly en.
REQ-013 SHALL have out_ready  input  1  downstream accepts frame.
REQ-014 SHALL have frame_err  output  1  one-cycle pulse on partial-frame discard.

Function
REQ-015 SHALL hold two banks (0/1) of N samples, a write index wr_idx (clog2(N) bits), a write bank pointer, a read bank pointer and one full flag per bank.
REQ-016 SHALL accept a sample only when in_valid && in_ready; in_ready = !full[wr_bank].
REQ-017 SHALL store an accepted sample in slot wr_idx, or bitrev(wr_idx) when BIT_REVERSE=1; no arithmetic or width change on data.
REQ-018 SHALL increment wr_idx on each accept; on accept at wr_idx=N-1: set full[wr_bank], toggle wr_bank, wr_idx to 0 (wrap).
REQ-019 SHALL drive en_out = full[rd_bank] and cplx_data_out = bank[rd_bank] contents; output stable while en_out && !out_ready.
REQ-020 SHALL on en_out && out_ready clear full[rd_bank] and toggle rd_bank.
REQ-021 SHALL give latency: last sample of a frame accepted at edge t -> en_out high in the cycle after edge t.
REQ-022 SHALL allow a frame completion into one bank and a read release of the other bank in the same cycle, both taking effect.
REQ-023 SHALL sustain one sample per cycle with no in_ready deassertion when out_ready is held high.
REQ-024 SHALL treat an accepted sample with in_sof=1 and wr_idx!=0 as frame restart: partial frame discarded, sample written to slot 0 (bit-reversed slot 0), wr_idx becomes 1, frame_err pulses the following cycle.
REQ-025 SHALL treat in_sof=1 at wr_idx=0 as normal; in_sof is optional for alignment.
REQ-026 SHALL ignore in_real/in_imag/in_sof when not accepted.

Reset
REQ-027 SHALL on rst_n low immediately clear: both full flags, wr_idx, both bank pointers, all bank data to 0, en_out 0, frame_err 0, cplx_data_out 0.
REQ-028 SHALL assert in_ready 1 from the first cycle after reset release.
REQ-029 SHALL discard any partial or unread frame on reset mid-operation; no en_out until a new complete frame.

Structure
REQ-030 SHALL place in shared package fft_pkg: bit-reverse function, clog2 index width constant, slot packing offset helpers (shared with butterfly).
REQ-031 SHALL instantiate sub-module fft_frame_bank twice: one N-slot register bank with slot write enable, packed read-out, full flag set/clear.

Verification (N=4, DATA_WIDTH=16)
REQ-032 SHALL cover reset: rst_n low mid-run -> en_out 0, frame_err 0, cplx_data_out 0; after release in_ready 1.
REQ-033 SHALL cover basic frame: samples (1,-1),(2,-2),(3,-3),(4,-4) back-to-back, out_ready=1 -> en_out high exactly one cycle after 4th accept; [15:0]=0x0001, [31:16]=0xFFFF, [111:96]=0x0004, [127:112]=0xFFFC.
REQ-034 SHALL cover BIT_REVERSE=1: reals 10,11,12,13 -> slots 0..3 hold reals 10,12,11,13.
REQ-035 SHALL cover backpressure: out_ready=0, in_valid held for 12 cycles -> 8 accepted, in_ready low after 8th, en_out held with frame 0; out_ready=1 -> frame 0 then frame 1 on consecutive cycles, in_ready high again.
REQ-036 SHALL cover mid-frame sof: 2 samples, then (9,9) with in_sof=1, then 3 samples -> frame_err one-cycle pulse, emitted frame slot 0 = (9,9), no frame contains the 2 discarded samples.
REQ-037 SHALL cover reset after 3 samples: no en_out; next 4 samples form one clean frame.
